dlfloat_divider: RTL and testbench

Sequential unsigned DLFloat-16 divider, the inverse operation of the team's combinational DLFloat multiplier. Computes quot = flp_a / flp_b using a radix-2 restoring mantissa divider, one quotient bit per cycle. Valid/ready handshake on both sides, so it drops into the same datapath as the multiplier. Operand format matches the multiplier: {exp[15:9], mant[8:0]}, no sign bit, bias 63, explicit leading one in mant[8], zero = all bits 0.

---
 rtl/dlfloat_pkg.sv | 41 ++++
 rtl/dlfloat_div_step.sv | 21 ++
 rtl/dlfloat_divider.sv | 123 ++++++++++++
 tb/tb_dlfloat_divider.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat-16 definitions: field layout, special encodings, field helpers
// and the divider state encoding.
package dlfloat_pkg;

    localparam int EXP_W  = 7;
    localparam int MANT_W = 9;
    localparam int BIAS   = 63;
    localparam int DLF_W  = EXP_W + MANT_W;
    localparam int CNT_W  = $clog2(MANT_W + 2);

    localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
    localparam logic [DLF_W-1:0] DLF_SAT  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } div_state_t;

    typedef struct packed {
        logic [DLF_W-1:0] quot;
        logic             dbz;
        logic             ovf;
        logic             unf;
    } dlf_result_t;

    function automatic logic [EXP_W-1:0] exp_of(input logic [DLF_W-1:0] x);
        return x[DLF_W-1:MANT_W];
    endfunction

    function automatic logic [MANT_W-1:0] mant_of(input logic [DLF_W-1:0] x);
        return x[MANT_W-1:0];
    endfunction

    // A missing leading one means zero, whatever the exponent field holds.
    function automatic logic is_zero(input logic [DLF_W-1:0] x);
        return (x[MANT_W-1] == 1'b0);
    endfunction

endpackage

// File: rtl/dlfloat_div_step.sv
// One radix-2 restoring division step: trial subtract, select, shift left.
module dlfloat_div_step
    import dlfloat_pkg::*;
(
    input  logic [MANT_W:0]   rem,
    input  logic [MANT_W-1:0] divisor,
    output logic [MANT_W:0]   rem_next,
    output logic              q_bit
);

    logic [MANT_W+1:0] trial;
    logic [MANT_W:0]   kept;

    always_comb begin
        trial    = {1'b0, rem} - {2'b00, divisor};
        q_bit    = ~trial[MANT_W+1];
        kept     = q_bit ? trial[MANT_W:0] : rem;
        rem_next = kept << 1;
    end

endmodule

// File: rtl/dlfloat_divider.sv
// Sequential DLFloat-16 divider: one quotient bit per cycle, valid/ready on
// both sides, results held stable in DONE until the consumer takes them.
module dlfloat_divider
    import dlfloat_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DLF_W-1:0] flp_a,
    input  logic [DLF_W-1:0] flp_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DLF_W-1:0] quot,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             underflow
);

    div_state_t        state, state_nxt;
    logic [DLF_W-1:0]  a_r, b_r;
    logic [MANT_W:0]   rem_r, rem_nxt, q_r;
    logic [MANT_W-1:0] mant_b;
    logic              q_bit;
    logic [CNT_W-1:0]  cnt_r;
    dlf_result_t       res;

    // Specials are resolved here too, so every result leaves through NORM.
    function automatic dlf_result_t norm_result(
        input logic [DLF_W-1:0] a,
        input logic [DLF_W-1:0] b,
        input logic [MANT_W:0]  q
    );
        dlf_result_t              r;
        logic signed [EXP_W+1:0]  e;
        logic [MANT_W-1:0]        m;
        r = '0;
        e = {2'b00, exp_of(a)} - {2'b00, exp_of(b)} + (EXP_W+2)'(BIAS)
            - {{(EXP_W+1){1'b0}}, ~q[MANT_W]};
        m = q[MANT_W] ? q[MANT_W:1] : q[MANT_W-1:0];
        if (is_zero(b)) begin
            r.quot = DLF_SAT;
            r.dbz  = 1'b1;
        end else if (is_zero(a)) begin
            r.quot = DLF_ZERO;
        end else if (e[EXP_W+1]) begin
            r.quot = DLF_ZERO;
            r.unf  = 1'b1;
        end else if (e[EXP_W]) begin
            r.quot = DLF_SAT;
            r.ovf  = 1'b1;
        end else begin
            r.quot = {e[EXP_W-1:0], m};
        end
        return r;
    endfunction

    assign mant_b    = mant_of(b_r);
    assign res       = norm_result(a_r, b_r, q_r);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    dlfloat_div_step u_step (
        .rem      (rem_r),
        .divisor  (mant_b),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)
                      state_nxt = (is_zero(flp_a) || is_zero(flp_b)) ? NORM : DIV;
            DIV:  if (cnt_r == CNT_W'(1)) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= '0;
            quot        <= DLF_ZERO;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= flp_a;
                    b_r   <= flp_b;
                    rem_r <= {1'b0, mant_of(flp_a)};
                    cnt_r <= CNT_W'(MANT_W + 1);
                end
                DIV: begin
                    rem_r <= rem_nxt;
                    q_r   <= {q_r[MANT_W-1:0], q_bit};
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                NORM: begin
                    quot        <= res.quot;
                    div_by_zero <= res.dbz;
                    overflow    <= res.ovf;
                    underflow   <= res.unf;
                end
                DONE: if (out_ready) begin
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat_divider.sv
// Scoreboard bench for dlfloat_divider: directed cases, backpressure, reset
// mid-divide and randomized operands against an arithmetic reference model.
module tb_dlfloat_divider;

    typedef struct packed {
        logic [15:0] q;
        logic        dbz;
        logic        ovf;
        logic        unf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] flp_a, flp_b, quot;
    logic        div_by_zero, overflow, underflow;

    res_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    dlfloat_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flp_a       (flp_a),
        .flp_b       (flp_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quot        (quot),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    // Quotient from plain integer arithmetic on the decoded fields.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
        res_t r;
        int ma, mb, q, e, m;
        r  = '0;
        ma = int'(a[8:0]);
        mb = int'(b[8:0]);
        if (b[8] == 1'b0) begin
            r.q = 16'hFFFF; r.dbz = 1'b1;
            return r;
        end
        if (a[8] == 1'b0) return r;
        q = (ma * 512) / mb;
        e = int'(a[15:9]) - int'(b[15:9]) + 63;
        if (q >= 512) m = q / 2;
        else begin m = q; e = e - 1; end
        if (e > 127) begin r.q = 16'hFFFF; r.ovf = 1'b1; end
        else if (e < 0) begin r.q = 16'h0000; r.unf = 1'b1; end
        else r.q = 16'(e * 512 + m);
        return r;
    endfunction

    // Monitor: a result is taken exactly when out_valid && out_ready at the next edge.
    always @(negedge clk) begin : monitor
        res_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {13'b0, quot, div_by_zero, overflow, underflow}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("result", {13'b0, quot, div_by_zero, overflow, underflow}, {13'b0, e});
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        flp_a = a; flp_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) sb.push_back(model(a, b));
    endtask

    task automatic latency(output int n);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_result(input bit bp);
        bit hs = 1'b0;
        int n  = 0;
        while (!hs && n < 200) begin
            out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            hs = out_valid && out_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!hs) chk("result_timeout", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
    endtask

    function automatic logic [15:0] rand_op();
        logic [6:0] e;
        logic [8:0] m;
        e = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(40, 86));
        m = {($urandom_range(0, 15) != 0), 8'($urandom)};
        return {e, m};
    endfunction

    logic [15:0] da   [8] = '{16'h7F00, 16'h8180, 16'h7F00, 16'h7F00, 16'h0000, 16'h7E00, 16'hFF00, 16'h0100};
    logic [15:0] db   [8] = '{16'h7F00, 16'h8100, 16'h7F80, 16'h0000, 16'h7F00, 16'h7F00, 16'h0100, 16'hFF00};
    int          dlat [8] = '{11, 11, 11, 1, 1, 1, 11, 11};

    initial begin
        int n;
        res_t bp_exp;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flp_a = '0; flp_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_outputs", {13'b0, quot, div_by_zero, overflow, underflow}, 32'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(da[i], db[i], 1'b1);
            latency(n);
            chk($sformatf("latency_%0d", i), 32'(n), 32'(dlat[i]));
            wait_result(1'b0);
        end

        // Backpressure: result and flags hold, input side stays closed.
        out_ready = 1'b0;
        bp_exp = model(16'hFF00, 16'h0100);
        issue(16'hFF00, 16'h0100, 1'b1);
        latency(n);
        chk("bp_latency", 32'(n), 32'd11);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {13'b0, quot, div_by_zero, overflow, underflow}, {13'b0, bp_exp});
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            in_valid = 1'(i % 2 == 0); flp_a = 16'h7F00; flp_b = 16'h7F00;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        chk("bp_out_valid_after", 32'(out_valid), 32'd0);
        chk("bp_flags_cleared", {29'b0, div_by_zero, overflow, underflow}, 32'd0);
        repeat (3) @(posedge clk); #1;
        chk("bp_no_ghost", 32'(out_valid), 32'd0);

        // Reset in the middle of DIV: that operation produces nothing.
        out_ready = 1'b1;
        issue(16'h7F00, 16'h7F80, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", 32'(quot), 32'd0);
        issue(16'h8180, 16'h8100, 1'b1);
        latency(n);
        chk("rst_latency", 32'(n), 32'd11);
        wait_result(1'b0);

        for (int i = 0; i < 300; i++) begin
            issue(rand_op(), rand_op(), 1'b1);
            wait_result(1'b1);
        end

        repeat (3) @(posedge clk); #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
